// File: rtl/level_sequencer_pkg.sv
// Shared constants for the level sequencer: state codes, seconds width and the
// per-level spawn interval helper.
package level_seq_pkg;

  localparam int SEC_W = 10;
  localparam logic [SEC_W-1:0] SEC_MAX = '1;

  typedef logic [2:0] state_t;

  localparam state_t ST_TITLE    = 3'd0;
  localparam state_t ST_INTRO    = 3'd1;
  localparam state_t ST_PLAY     = 3'd2;
  localparam state_t ST_CLEAR    = 3'd3;
  localparam state_t ST_WIN      = 3'd4;
  localparam state_t ST_GAMEOVER = 3'd5;

  // Each level halves the spawn interval; never let it collapse below one cycle.
  function automatic logic [31:0] spawn_period(input logic [31:0] base, input int unsigned lvl);
    logic [31:0] p;
    p = (lvl >= 32) ? 32'd0 : (base >> lvl);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Keyboard/collision inputs and screen/object outputs of the level sequencer.
// PAUSE_EN adds pause_key and paused.
interface level_sequencer_if
  import level_seq_pkg::*;
#(
  parameter int NUM_OBJ = 30,
  parameter int LVL_W   = 2,
  parameter int LIV_W   = 2
);
  logic [7:0]         keycode;
  logic [1:0]         collision;
  logic               level_done;
  logic [NUM_OBJ-1:0] obj_active;
  logic [LVL_W-1:0]   level;
  logic [LIV_W-1:0]   lives;
  logic [SEC_W-1:0]   seconds;
  logic               title;
  logic               intro;
  logic               playing;
  logic               win;
  logic               game_over;
  logic               blink;
`ifdef PAUSE_EN
  logic [7:0]         pause_key;
  logic               paused;

  modport master (
    output keycode, collision, level_done, pause_key,
    input  obj_active, level, lives, seconds, title, intro, playing, win, game_over, blink, paused
  );
  modport slave (
    input  keycode, collision, level_done, pause_key,
    output obj_active, level, lives, seconds, title, intro, playing, win, game_over, blink, paused
  );
`else
  modport master (
    output keycode, collision, level_done,
    input  obj_active, level, lives, seconds, title, intro, playing, win, game_over, blink
  );
  modport slave (
    input  keycode, collision, level_done,
    output obj_active, level, lives, seconds, title, intro, playing, win, game_over, blink
  );
`endif
endinterface

// File: rtl/level_sequencer_tick_divider.sv
// Prescaler giving a one-cycle sec_pulse every TICKS_PER_SEC enabled cycles and
// blink_pulse every BLINK_TICKS; clr restarts both counts from zero.
module tick_divider #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int BLINK_TICKS   = 25000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic sec_pulse,
  output logic blink_pulse
);
  localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0] SEC_LAST = SW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_TICKS - 1);

  logic [SW-1:0] sec_cnt;
  logic [BW-1:0] blk_cnt;

  assign sec_pulse   = en && (sec_cnt == SEC_LAST);
  assign blink_pulse = en && (blk_cnt == BLK_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sec_cnt <= '0;
      blk_cnt <= '0;
    end else if (clr) begin
      sec_cnt <= '0;
      blk_cnt <= '0;
    end else if (en) begin
      sec_cnt <= sec_pulse   ? '0 : sec_cnt + SW'(1);
      blk_cnt <= blink_pulse ? '0 : blk_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-flow sequencer: title, intro, timed spawning, clear, win/game-over with lives.
// Outputs registered or decoded from registered state; PAUSE_EN adds a pause toggle.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int         TICKS_PER_SEC    = 50000000,
  parameter int         NUM_LEVELS       = 3,
  parameter int         SPAWNS_PER_LEVEL = 10,
  parameter int         BASE_SPAWN_TICKS = 100000000,
  parameter int         INTRO_SEC        = 2,
  parameter int         END_SEC          = 5,
  parameter int         LIVES            = 3,
  parameter logic [7:0] START_KEY        = 8'd40,
  parameter int         BLINK_TICKS      = 25000000
) (
  input logic          Clk,
  input logic          Reset,
  level_sequencer_if.slave bus
);
  localparam int NUM_OBJ = NUM_LEVELS * SPAWNS_PER_LEVEL;
  localparam int LVL_W   = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int LIV_W   = $clog2(LIVES + 1);
  localparam int CNT_W   = $clog2(SPAWNS_PER_LEVEL + 1);

  localparam logic [SEC_W-1:0] INTRO_LAST = SEC_W'((INTRO_SEC > 0) ? INTRO_SEC - 1 : 0);
  localparam logic [SEC_W-1:0] END_LAST   = SEC_W'((END_SEC > 0) ? END_SEC - 1 : 0);
  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWNS_PER_LEVEL - 1);
  localparam logic [LVL_W-1:0] LEVEL_LAST = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LIV_W-1:0] LIVES_INIT = LIV_W'(LIVES);

  state_t           state, st_nxt;
  logic [LVL_W-1:0] level_q, level_nxt;
  logic [LIV_W-1:0] lives_q, lives_nxt;
  logic [CNT_W-1:0] spawn_cnt, spawn_nxt;
  logic [31:0]      spawn_tmr, tmr_nxt, period;
  logic [SEC_W-1:0] seconds_q;
  logic             blink_q;
  logic             trans, frozen, in_play, hit;
  logic             sec_pulse, blink_pulse, intro_done, end_done;
  logic [NUM_OBJ-1:0] obj_vec;
  int               lo;

  tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC),
    .BLINK_TICKS  (BLINK_TICKS)
  ) u_div (
    .Clk        (Clk),
    .Reset      (Reset),
    .clr        (trans),
    .en         (!frozen),
    .sec_pulse  (sec_pulse),
    .blink_pulse(blink_pulse)
  );

  assign in_play    = (state == ST_PLAY) || (state == ST_CLEAR);
  assign hit        = |bus.collision;
  assign period     = spawn_period(32'(BASE_SPAWN_TICKS), int'(level_q));
  // Exit fires on the edge where seconds would reach the limit, not one cycle later.
  assign intro_done = (INTRO_SEC == 0) || (sec_pulse && seconds_q == INTRO_LAST);
  assign end_done   = (END_SEC == 0) || (sec_pulse && seconds_q == END_LAST);
  assign trans      = (st_nxt != state);

  always_comb begin
    st_nxt    = state;
    level_nxt = level_q;
    lives_nxt = lives_q;
    spawn_nxt = spawn_cnt;
    tmr_nxt   = spawn_tmr;
    case (state)
      ST_TITLE: begin
        if (bus.keycode == START_KEY) begin
          st_nxt    = ST_INTRO;
          level_nxt = '0;
          lives_nxt = LIVES_INIT;
        end
      end
      ST_INTRO: begin
        if (intro_done) begin
          st_nxt    = ST_PLAY;
          spawn_nxt = '0;
          tmr_nxt   = '0;
        end
      end
      ST_PLAY, ST_CLEAR: begin
        if (!frozen) begin
          // Collision outranks both spawning and level_done.
          if (hit) begin
            lives_nxt = lives_q - LIV_W'(1);
            spawn_nxt = '0;
            st_nxt    = (lives_q == LIV_W'(1)) ? ST_GAMEOVER : ST_INTRO;
          end else if (state == ST_PLAY) begin
            if (spawn_tmr == period - 32'd1) begin
              tmr_nxt   = '0;
              spawn_nxt = spawn_cnt + CNT_W'(1);
              if (spawn_cnt == SPAWN_LAST) st_nxt = ST_CLEAR;
            end else begin
              tmr_nxt = spawn_tmr + 32'd1;
            end
          end else if (bus.level_done) begin
            if (level_q == LEVEL_LAST) begin
              st_nxt = ST_WIN;
            end else begin
              level_nxt = level_q + LVL_W'(1);
              st_nxt    = ST_INTRO;
            end
          end
        end
      end
      ST_WIN, ST_GAMEOVER: begin
        if (end_done) st_nxt = ST_TITLE;
      end
      default: st_nxt = ST_TITLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_TITLE;
      level_q   <= '0;
      lives_q   <= LIVES_INIT;
      spawn_cnt <= '0;
      spawn_tmr <= '0;
      seconds_q <= '0;
      blink_q   <= 1'b0;
    end else begin
      state     <= st_nxt;
      level_q   <= level_nxt;
      lives_q   <= lives_nxt;
      spawn_cnt <= spawn_nxt;
      spawn_tmr <= tmr_nxt;
      if (trans) begin
        seconds_q <= '0;
        blink_q   <= 1'b0;
      end else begin
        if (sec_pulse && seconds_q != SEC_MAX) seconds_q <= seconds_q + SEC_W'(1);
        if (blink_pulse && (state == ST_TITLE || state == ST_GAMEOVER)) blink_q <= ~blink_q;
      end
    end
  end

`ifdef PAUSE_EN
  logic paused_q, pmatch, pmatch_q;

  assign pmatch = (bus.keycode == bus.pause_key);
  assign frozen = paused_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      paused_q <= 1'b0;
      pmatch_q <= 1'b0;
    end else begin
      pmatch_q <= pmatch;
      if (trans)                              paused_q <= 1'b0;
      else if (in_play && pmatch && !pmatch_q) paused_q <= ~paused_q;
    end
  end

  assign bus.paused = paused_q;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    obj_vec = '0;
    lo      = int'(level_q) * SPAWNS_PER_LEVEL;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_vec[i] = in_play && (i >= lo) && (i < lo + int'(spawn_cnt));
    end
  end

  assign bus.obj_active = obj_vec;
  assign bus.level      = level_q;
  assign bus.lives      = lives_q;
  assign bus.seconds    = seconds_q;
  assign bus.title      = (state == ST_TITLE);
  assign bus.intro      = (state == ST_INTRO);
  assign bus.playing    = in_play;
  assign bus.win        = (state == ST_WIN);
  assign bus.game_over  = (state == ST_GAMEOVER);
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed walk through the game flow plus randomized play, all checked against an
// elapsed-time model of the sequencer.
module tb_level_sequencer;
  localparam int TPS = 10, NL = 2, SPL = 3, NOBJ = 6, BASE = 8;
  localparam int INTRO = 2, ENDS = 1, LV = 2, BLK = 4;
  localparam int LVL_W = 1, LIV_W = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  level_sequencer_if #(.NUM_OBJ(NOBJ), .LVL_W(LVL_W), .LIV_W(LIV_W)) bus();

  level_sequencer #(
    .TICKS_PER_SEC(TPS), .NUM_LEVELS(NL), .SPAWNS_PER_LEVEL(SPL),
    .BASE_SPAWN_TICKS(BASE), .INTRO_SEC(INTRO), .END_SEC(ENDS),
    .LIVES(LV), .START_KEY(8'd40), .BLINK_TICKS(BLK)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: state plus the edge at which it was entered; everything else is elapsed time.
  typedef enum int {M_TITLE, M_INTRO, M_PLAY, M_CLEAR, M_WIN, M_OVER} mst_t;
  mst_t m_st;
  int   m_entry, m_level, m_lives, n;

  function automatic int period_of(input int lvl);
    int p;
    p = BASE >> lvl;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic enter(input mst_t s);
    m_st    = s;
    m_entry = n;
  endtask

  task automatic model_edge(input logic [7:0] key, input logic [1:0] coll, input logic ld);
    int e;
    e = n - m_entry;
    case (m_st)
      M_TITLE: if (key == 8'd40) begin m_level = 0; m_lives = LV; enter(M_INTRO); end
      M_INTRO: if (e == INTRO * TPS) enter(M_PLAY);
      M_PLAY, M_CLEAR: begin
        if (coll != 2'b00) begin
          m_lives--;
          if (m_lives == 0) enter(M_OVER);
          else enter(M_INTRO);
        end else if (m_st == M_PLAY && e == SPL * period_of(m_level)) begin
          enter(M_CLEAR);
        end else if (m_st == M_CLEAR && ld) begin
          if (m_level == NL - 1) enter(M_WIN);
          else begin m_level++; enter(M_INTRO); end
        end
      end
      default: if (e == ENDS * TPS) enter(M_TITLE);
    endcase
  endtask

  task automatic compare_all();
    int e, spn, secs;
    logic [NOBJ-1:0] obj;
    logic [4:0] fl;
    logic bl;
    e    = n - m_entry;
    spn  = (m_st == M_PLAY) ? e / period_of(m_level) : ((m_st == M_CLEAR) ? SPL : 0);
    obj  = NOBJ'(((1 << spn) - 1) << (m_level * SPL));
    secs = (e / TPS > 1023) ? 1023 : e / TPS;
    fl   = {m_st == M_TITLE, m_st == M_INTRO, (m_st == M_PLAY) || (m_st == M_CLEAR),
            m_st == M_WIN, m_st == M_OVER};
    bl   = (m_st == M_TITLE || m_st == M_OVER) ? 1'((e / BLK) % 2) : 1'b0;
    check_eq("flags", {bus.title, bus.intro, bus.playing, bus.win, bus.game_over}, fl);
    check_eq("level", bus.level, m_level);
    check_eq("lives", bus.lives, m_lives);
    check_eq("seconds", bus.seconds, secs);
    check_eq("obj_active", bus.obj_active, obj);
    check_eq("blink", bus.blink, bl);
  endtask

  task automatic step(input logic [7:0] key, input logic [1:0] coll, input logic ld);
    bus.keycode    = key;
    bus.collision  = coll;
    bus.level_done = ld;
    @(posedge Clk);
    n++;
    model_edge(key, coll, ld);
    @(negedge Clk);
    compare_all();
    bus.keycode    = 8'd0;
    bus.collision  = 2'b00;
    bus.level_done = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(8'd0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    m_st = M_TITLE; m_level = 0; m_lives = LV; m_entry = n;
    compare_all();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.keycode = 8'd0; bus.collision = 2'b00; bus.level_done = 1'b0;
    n = 0;
    do_reset();
    check_eq("rst_title", bus.title, 1);
    check_eq("rst_lives", bus.lives, 2);
    check_eq("rst_obj", bus.obj_active, 0);

    // Start and intro length
    step(8'd40, 2'b00, 1'b0);
    check_eq("start_intro", bus.intro, 1);
    check_eq("start_level", bus.level, 0);
    idle(19);
    check_eq("intro_hold", bus.playing, 0);
    idle(1);
    check_eq("play_at_20", bus.playing, 1);

    // Level 0 releases every 8 cycles, then level 1 every 4
    idle(7);  check_eq("l0_obj_7", bus.obj_active, 6'b000000);
    idle(1);  check_eq("l0_obj_8", bus.obj_active, 6'b000001);
    idle(8);  check_eq("l0_obj_16", bus.obj_active, 6'b000011);
    idle(8);  check_eq("l0_obj_24", bus.obj_active, 6'b000111);
    step(8'd0, 2'b00, 1'b1);
    check_eq("l0_done_intro", bus.intro, 1);
    check_eq("l0_done_level", bus.level, 1);
    idle(20); idle(4);
    check_eq("l1_obj_4", bus.obj_active, 6'b001000);
    idle(4);
    check_eq("l1_obj_8", bus.obj_active, 6'b011000);

    // Collisions: lose a life, then game over
    step(8'd0, 2'b01, 1'b0);
    check_eq("hit1_lives", bus.lives, 1);
    check_eq("hit1_level", bus.level, 1);
    check_eq("hit1_obj", bus.obj_active, 0);
    idle(22);
    step(8'd0, 2'b01, 1'b0);
    check_eq("hit2_over", bus.game_over, 1);
    check_eq("hit2_lives", bus.lives, 0);
    idle(9);  check_eq("over_hold", bus.title, 0);
    idle(1);  check_eq("over_title", bus.title, 1);

    // Collision and level_done together in CLEAR
    step(8'd40, 2'b00, 1'b0);
    idle(44);
    step(8'd0, 2'b10, 1'b1);
    check_eq("both_lives", bus.lives, 1);
    check_eq("both_level", bus.level, 0);
    check_eq("both_intro", bus.intro, 1);

    // Finish both levels, win, blink in title
    idle(44);
    step(8'd0, 2'b00, 1'b1);
    idle(32);
    step(8'd0, 2'b00, 1'b1);
    check_eq("win_flag", bus.win, 1);
    idle(10); check_eq("win_title", bus.title, 1);
    idle(3);  check_eq("blink_3", bus.blink, 0);
    idle(1);  check_eq("blink_4", bus.blink, 1);
    idle(4);  check_eq("blink_8", bus.blink, 0);

    // Asynchronous reset mid-play
    step(8'd40, 2'b00, 1'b0);
    idle(35);
    check_eq("mid_sec", bus.seconds, 1);
    do_reset();
    check_eq("arst_title", bus.title, 1);
    check_eq("arst_play", bus.playing, 0);
    check_eq("arst_sec", bus.seconds, 0);
    check_eq("arst_lives", bus.lives, 2);

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      logic [7:0] k;
      logic [1:0] co;
      logic       ld;
      k  = ($urandom_range(0, 7) == 0) ? 8'd40 : 8'($urandom_range(0, 255));
      co = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ld = ($urandom_range(0, 4) == 0);
      step(k, co, ld);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
